// File: rtl/control_sequencer_if.sv
// Bundle between the multi-cycle control sequencer and the core datapath.
// Master drives start/instr/zero; slave (the sequencer) drives controls.
interface control_sequencer_if #(
    parameter int OPW   = 4,
    parameter int MCW   = 9,
    parameter int CNT_W = 16
);
    logic             start;
    logic [MCW-1:0]   instr;
    logic             zero;
    logic             RegDst;
    logic             Branch;
    logic             MemtoReg;
    logic             MemWrite;
    logic             ALUSrc;
    logic             RegWrite;
    logic [OPW-1:0]   ALUOp;
    logic             pc_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] retired;

    modport master (
        output start, instr, zero,
        input  RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite,
        input  ALUOp, pc_en, busy, done, retired
    );

    modport slave (
        input  start, instr, zero,
        output RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite,
        output ALUOp, pc_en, busy, done, retired
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control unit: decodes the 4-bit opcode, sequences EXEC and
// load-wait cycles, strobes the PC and counts retired instructions.
module control_sequencer #(
    parameter int OPW      = 4,
    parameter int MCW      = 9,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input logic                clk,
    input logic                reset,
    control_sequencer_if.slave bus
);
    localparam int WW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, MEM, HALT} state_t;

    state_t           state, next;
    logic [WW-1:0]    cnt;
    logic [CNT_W-1:0] retired;
    logic             armed;
    logic             inc;
    logic             load;
    logic [3:0]       alu;
    logic [3:0]       opcode;

    assign opcode      = bus.instr[MCW-1 -: 4];
    assign bus.ALUOp   = OPW'(alu);
    assign bus.retired = retired;
    assign bus.RegDst  = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            retired <= '0;
            armed   <= 1'b0;
        end else begin
            state <= next;
            if (load)
                cnt <= WW'(LOAD_LAT - 1);
            else if (state == MEM && cnt != '0)
                cnt <= cnt - 1'b1;
            if (inc && retired != '1)
                retired <= retired + 1'b1;
            // restart only after start has been seen low while halted
            armed <= (state == HALT) && (armed || !bus.start);
        end
    end

    always_comb begin
        next         = state;
        inc          = 1'b0;
        load         = 1'b0;
        alu          = 4'h0;
        bus.Branch   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.MemWrite = 1'b0;
        bus.ALUSrc   = 1'b0;
        bus.RegWrite = 1'b0;
        bus.pc_en    = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start)
                    next = EXEC;
            end
            EXEC: begin
                bus.busy  = 1'b1;
                bus.pc_en = 1'b1;
                inc       = 1'b1;
                unique case (opcode)
                    4'b0000: begin
                        bus.MemWrite = 1'b1;
                        alu          = 4'hF;
                    end
                    4'b0001: begin bus.RegWrite = 1'b1; alu = 4'h0; end
                    4'b0011: begin bus.RegWrite = 1'b1; alu = 4'h1; end
                    4'b0100: begin bus.RegWrite = 1'b1; alu = 4'h2; end
                    4'b0101: begin bus.RegWrite = 1'b1; alu = 4'h3; end
                    4'b0110: begin bus.RegWrite = 1'b1; alu = 4'h4; end
                    4'b0111: begin bus.RegWrite = 1'b1; alu = 4'h5; end
                    4'b1001: begin
                        bus.ALUSrc   = 1'b1;
                        bus.RegWrite = 1'b1;
                        alu          = 4'hF;
                    end
                    4'b1000: begin
                        bus.Branch = 1'b1;
                        alu        = 4'h1;
                    end
                    4'b0010: begin
                        bus.MemtoReg = 1'b1;
                        alu          = 4'hF;
                        bus.pc_en    = 1'b0;
                        inc          = 1'b0;
                        load         = 1'b1;
                        next         = MEM;
                    end
                    4'b1111: begin
                        bus.pc_en = 1'b0;
                        inc       = 1'b0;
                        next      = HALT;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                bus.busy     = 1'b1;
                bus.MemtoReg = 1'b1;
                alu          = 4'hF;
                if (cnt == '0) begin
                    bus.RegWrite = 1'b1;
                    bus.pc_en    = 1'b1;
                    inc          = 1'b1;
                    next         = EXEC;
                end
            end
            HALT: begin
                bus.done = 1'b1;
                if (armed && bus.start)
                    next = EXEC;
            end
            default: next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: two sequencer instances (LOAD_LAT=3 and a 2-bit counter
// with LOAD_LAT=1) driven by directed vectors, checked by one monitor.
module tb_control_sequencer;
    typedef struct {
        int          id;
        logic [12:0] ctl;
        int          ret;
    } exp_t;

    localparam logic [3:0] ST = 4'h0, ADD = 4'h1, LD = 4'h2, SUB = 4'h3;
    localparam logic [3:0] AND = 4'h4, XOR = 4'h5, SHL = 4'h6, SHR = 4'h7;
    localparam logic [3:0] BR = 4'h8, MOVI = 4'h9, NOP = 4'hA, HLT = 4'hF;

    // {RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp, pc_en, busy, done}
    function automatic logic [12:0] c(input logic [4:0] f, input logic [3:0] a,
                                      input logic [2:0] t);
        return {1'b0, f, a, t};
    endfunction

    localparam logic [12:0] E_ID   = 13'd0;
    localparam logic [12:0] E_DN   = {1'b0, 5'b00000, 4'h0, 3'b001};
    localparam logic [12:0] E_HX   = {1'b0, 5'b00000, 4'h0, 3'b010};
    localparam logic [12:0] E_ADD  = {1'b0, 5'b00001, 4'h0, 3'b110};
    localparam logic [12:0] E_SUB  = {1'b0, 5'b00001, 4'h1, 3'b110};
    localparam logic [12:0] E_AND  = {1'b0, 5'b00001, 4'h2, 3'b110};
    localparam logic [12:0] E_XOR  = {1'b0, 5'b00001, 4'h3, 3'b110};
    localparam logic [12:0] E_SHL  = {1'b0, 5'b00001, 4'h4, 3'b110};
    localparam logic [12:0] E_SHR  = {1'b0, 5'b00001, 4'h5, 3'b110};
    localparam logic [12:0] E_ST   = {1'b0, 5'b00100, 4'hF, 3'b110};
    localparam logic [12:0] E_MOVI = {1'b0, 5'b00011, 4'hF, 3'b110};
    localparam logic [12:0] E_BR   = {1'b0, 5'b10000, 4'h1, 3'b110};
    localparam logic [12:0] E_NOP  = {1'b0, 5'b00000, 4'h0, 3'b110};
    localparam logic [12:0] E_LDW  = {1'b0, 5'b01000, 4'hF, 3'b010};
    localparam logic [12:0] E_LDF  = {1'b0, 5'b01001, 4'hF, 3'b110};

    logic clk = 1'b0;
    logic ra  = 1'b1;
    logic rb  = 1'b1;
    always #5 clk = ~clk;

    control_sequencer_if #(.OPW(4), .MCW(9), .CNT_W(16)) ifa ();
    control_sequencer_if #(.OPW(4), .MCW(9), .CNT_W(2))  ifb ();

    control_sequencer #(.OPW(4), .MCW(9), .LOAD_LAT(3), .CNT_W(16)) dut_a (
        .clk(clk), .reset(ra), .bus(ifa)
    );
    control_sequencer #(.OPW(4), .MCW(9), .LOAD_LAT(1), .CNT_W(2)) dut_b (
        .clk(clk), .reset(rb), .bus(ifb)
    );

    logic [12:0] ctl_a, ctl_b;
    assign ctl_a = {ifa.RegDst, ifa.Branch, ifa.MemtoReg, ifa.MemWrite, ifa.ALUSrc,
                    ifa.RegWrite, ifa.ALUOp, ifa.pc_en, ifa.busy, ifa.done};
    assign ctl_b = {ifb.RegDst, ifb.Branch, ifb.MemtoReg, ifb.MemWrite, ifb.ALUSrc,
                    ifb.RegWrite, ifb.ALUOp, ifb.pc_en, ifb.busy, ifb.done};

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   ida = 0;
    int   idb = 0;

    task automatic cmp(input string nm, input exp_t e, input logic [12:0] act,
                       input int ret);
        checks++;
        if (act !== e.ctl || ret != e.ret) begin
            errors++;
            $display("FAIL %s step %0d: got ctl=%b retired=%0d, want ctl=%b retired=%0d",
                     nm, e.id, act, ret, e.ctl, e.ret);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() != 0) begin
            e = qa.pop_front();
            cmp("dut_a", e, ctl_a, int'(ifa.retired));
        end
        if (qb.size() != 0) begin
            e = qb.pop_front();
            cmp("dut_b", e, ctl_b, int'(ifb.retired));
        end
    end

    task automatic sa(input logic r, input logic s, input logic [3:0] op,
                      input logic z, input logic [12:0] e, input int ret);
        exp_t x;
        @(posedge clk);
        #1;
        ra        = r;
        ifa.start = s;
        ifa.instr = {op, 5'b00000};
        ifa.zero  = z;
        x.id  = ida++;
        x.ctl = e;
        x.ret = ret;
        qa.push_back(x);
    endtask

    task automatic sb(input logic r, input logic s, input logic [3:0] op,
                      input logic [12:0] e, input int ret);
        exp_t x;
        @(posedge clk);
        #1;
        rb        = r;
        ifb.start = s;
        ifb.instr = {op, 5'b00000};
        ifb.zero  = 1'b0;
        x.id  = idb++;
        x.ctl = e;
        x.ret = ret;
        qb.push_back(x);
    endtask

    initial begin
        ifa.start = 1'b0; ifa.instr = '0; ifa.zero = 1'b0;
        ifb.start = 1'b0; ifb.instr = '0; ifb.zero = 1'b0;
        repeat (2) @(posedge clk);
        fork
            begin
                sa(0, 1, ADD, 0, E_ID, 0);
                sa(0, 0, ADD, 0, E_ADD, 0);
                sa(0, 0, SUB, 0, E_SUB, 1);
                sa(0, 0, ST, 0, E_ST, 2);
                sa(0, 0, HLT, 0, E_HX, 3);
                sa(0, 0, HLT, 0, E_DN, 3);
                sa(0, 1, LD, 0, E_DN, 3);
                sa(0, 1, LD, 0, E_LDW, 3);
                sa(0, 0, LD, 0, E_LDW, 3);
                sa(0, 0, LD, 0, E_LDW, 3);
                sa(0, 0, LD, 0, E_LDF, 3);
                sa(0, 0, BR, 1, E_BR, 4);
                sa(0, 0, BR, 0, E_BR, 5);
                sa(0, 1, HLT, 0, E_HX, 6);
                sa(0, 1, HLT, 0, E_DN, 6);
                sa(0, 1, HLT, 0, E_DN, 6);
                sa(0, 0, HLT, 0, E_DN, 6);
                sa(0, 1, ADD, 0, E_DN, 6);
                sa(0, 0, ADD, 0, E_ADD, 6);
                sa(1, 0, ADD, 0, E_ADD, 7);
                sa(1, 0, ADD, 0, E_ID, 0);
                sa(1, 0, ADD, 0, E_ID, 0);
                sa(0, 0, ADD, 0, E_ID, 0);
                sa(0, 1, NOP, 0, E_ID, 0);
                sa(0, 0, NOP, 0, E_NOP, 0);
                sa(0, 0, MOVI, 0, E_MOVI, 1);
                sa(0, 0, AND, 0, E_AND, 2);
                sa(0, 0, XOR, 0, E_XOR, 3);
                sa(0, 0, SHL, 0, E_SHL, 4);
                sa(0, 0, SHR, 0, E_SHR, 5);
                sa(0, 0, HLT, 0, E_HX, 6);
                sa(0, 0, HLT, 0, E_DN, 6);
                sa(0, 1, LD, 0, E_DN, 6);
                sa(0, 0, LD, 0, E_LDW, 6);
                sa(1, 0, LD, 0, E_LDW, 6);
                sa(1, 0, LD, 0, E_ID, 0);
                sa(0, 0, LD, 0, E_ID, 0);
            end
            begin
                sb(0, 1, ADD, E_ID, 0);
                sb(0, 0, ADD, E_ADD, 0);
                sb(0, 0, ADD, E_ADD, 1);
                sb(0, 0, ADD, E_ADD, 2);
                sb(0, 0, ADD, E_ADD, 3);
                sb(0, 0, ADD, E_ADD, 3);
                sb(0, 0, LD, E_LDW, 3);
                sb(0, 0, LD, E_LDF, 3);
                sb(0, 0, HLT, E_HX, 3);
                sb(0, 0, HLT, E_DN, 3);
                sb(1, 0, HLT, E_DN, 3);
                sb(1, 0, ADD, E_ID, 0);
                sb(0, 0, ADD, E_ID, 0);
            end
        join
        @(negedge clk);
        #1;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", qa.size(), qb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
